zero_detector_bit_serializer: RTL and testbench
===============================================

// Module: zero_detector_bit_serializer
// PURPOSE
//   Upstream feed stage for the Mealy zero detector. Accepts parallel words over a valid/ready
//   handshake and shifts them out one bit per clock on x_out. x_out drives the detector's
//   serial input x_in, which the detector samples on the same clock. Between words the line
//   holds a constant idle level, so the detector sees no false zeros.
// PARAMETERS
//   WIDTH       8  data word width in bits (legal range 2..32)
//   GAP_CYCLES  2  idle-bit cycles inserted after each word (0 = no gap)
//   MSB_FIRST   1  1: bit[WIDTH-1] is sent first; 0: bit[0] is sent first
//   IDLE_BIT    1  level on x_out while not sending data (1 = never triggers the zero detector)
// PORTS
//   clock       in   1      single clock; all state changes on its rising edge
//   reset       in   1      asynchronous, active-low reset (0 = in reset)
//   load_data   in   WIDTH  word to serialize; sampled on the accept edge
//   load_valid  in   1      load_data is valid
//   load_ready  out  1      block can accept a word
//   x_out       out  1      serial bit stream; connects to the detector's x_in
//   x_valid     out  1      x_out carries a data bit (or the parity bit)
//   busy        out  1      a word is in flight (SHIFT, PARITY or GAP state)
//   word_count  out  16     number of fully transmitted words; wraps 16'hFFFF -> 0
// BEHAVIOUR
//   - Reset (reset=0, asynchronous): state=IDLE, x_out=IDLE_BIT, x_valid=0, busy=0,
//     load_ready=0, word_count=0. load_ready rises at the first rising edge after reset=1.
//   - All outputs are registered. No combinational path from any input to any output.
//   - FSM states: IDLE -> SHIFT -> [PARITY] -> GAP -> IDLE.
//     - GAP is skipped when GAP_CYCLES=0. PARITY exists only with the option macro.
//   - IDLE: load_ready=1. Accept edge E0 is a rising edge with load_valid=1 and load_ready=1.
//     - At E0 the shift register loads and the first bit appears on x_out.
//     - Also at E0: x_valid=1, busy=1, load_ready=0.
//   - SHIFT: one bit per cycle. Bits k=0..WIDTH-1 are on x_out during the cycle after edge E(k).
//     - A bit counter of $clog2(WIDTH+1) bits counts the bits sent.
//   - At the edge after the last data bit:
//     - word_count increments (or after the parity bit, when the macro is on).
//     - x_out=IDLE_BIT and x_valid=0.
//     - State moves to GAP, or straight to IDLE when GAP_CYCLES=0.
//   - GAP: holds IDLE_BIT for exactly GAP_CYCLES cycles, then goes to IDLE.
//     - load_ready=1 and busy=0 from that IDLE edge onward.
//   - Throughput: one word per WIDTH+GAP_CYCLES+1 cycles (+1 more with parity).
//     - There is no back-to-back skid.
//   - load_valid while not ready: ignored. The word is not latched.
//     - Upstream must hold load_data and load_valid until it sees load_ready.
//   - load_data changing mid-word has no effect. The word was captured at E0.
//   - Reset mid-word: the in-flight word is dropped and not counted. Outputs take reset values.
// CONFIGURATION
//   - SERIALIZER_PARITY_EN defined:
//     - After the last data bit, one even-parity bit (^data) is sent with x_valid=1.
//     - word_count increments after that bit.
//   - Not defined: no PARITY state, x_valid is high for exactly WIDTH cycles per word,
//     and there is no parity logic.
// STRUCTURE
//   - Shared package zero_det_pkg holds:
//     - state encoding localparams S_IDLE, S_SHIFT, S_PARITY, S_GAP (2-bit);
//     - the default idle level;
//     - the word_count width constant WCNT_W=16.
//   - One sub-module, serializer_shift_reg:
//     - WIDTH-bit load/shift register with a MSB_FIRST direction select;
//     - running parity accumulator.
//   - The FSM, bit counter, gap counter and word_count stay in the top module.
// TESTING (WIDTH=8, GAP_CYCLES=2, MSB_FIRST=1, IDLE_BIT=1 unless noted)
//   1. Reset released, load 8'hA5 at E0:
//      x_out=1,0,1,0,0,1,0,1 after E0..E7 with x_valid=1; then 1,1 with x_valid=0;
//      load_ready=1 after E10; word_count=1.
//   2. MSB_FIRST=0, load 8'h01: x_out=1,0,0,0,0,0,0,0.
//      Detector downstream asserts y_out on the zero bits.
//   3. load_valid held high with 8'hFF then 8'h00: second word accepted only after E10;
//      x_out never drops to 0 between words; word_count=2.
//   4. reset=0 pulsed at bit 4 of 8'h3C:
//      x_out=1, x_valid=0, word_count=0 asynchronously; no further bits sent;
//      load_ready=1 one edge after release.
//   5. Preload word_count via 65535 words (or force): the next word completes -> word_count=0.
//   6. SERIALIZER_PARITY_EN, load 8'h07: 8 data bits, then parity bit 1 with x_valid=1,
//      then 2 gap cycles; load_ready after E11.

Source files
------------

// File: rtl/zero_det_pkg.sv
// zero_det_pkg: shared FSM state encoding, default idle level and word counter width
package zero_det_pkg;
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_GAP    = 2'd3
    } state_t;
    localparam logic IDLE_LVL = 1'b1;
    localparam int   WCNT_W   = 16;
endpackage

// File: rtl/serializer_shift_reg.sv
// serializer_shift_reg: WIDTH-bit load/shift register with direction select and running parity
// Ports: clock, reset (async active-low), load_i (capture data_i), shift_i (advance one bit),
//        data_i (word), bit_o (bit to drive onto the line this edge), parity_o (even parity of
//        bits sent so far; present only with SERIALIZER_PARITY_EN)
module serializer_shift_reg #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
`ifdef SERIALIZER_PARITY_EN
    output logic             parity_o,
`endif
    output logic             bit_o
);
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] src;
    // The register holds the bits still to go; the head bit is emitted on the same edge it is consumed.
    assign src   = load_i ? data_i : sr_q;
    assign bit_o = (MSB_FIRST != 0) ? src[WIDTH-1] : src[0];
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            sr_q <= '0;
        else if (load_i || shift_i)
            sr_q <= (MSB_FIRST != 0) ? {src[WIDTH-2:0], 1'b0} : {1'b0, src[WIDTH-1:1]};
    end
`ifdef SERIALIZER_PARITY_EN
    logic par_q;
    assign parity_o = par_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            par_q <= 1'b0;
        else if (load_i || shift_i)
            par_q <= (par_q & ~load_i) ^ bit_o;
    end
`endif
endmodule

// File: rtl/zero_detector_bit_serializer.sv
// zero_detector_bit_serializer: valid/ready word loader that shifts words out one bit per clock
// Ports: clock, reset (async active-low), load_data/load_valid/load_ready (word handshake),
//        x_out (serial line, IDLE_BIT when idle), x_valid (data/parity bit on x_out),
//        busy (word in flight), word_count (completed words, wraps)
// Option: define SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module zero_detector_bit_serializer
    import zero_det_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   GAP_CYCLES = 2,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_BIT   = IDLE_LVL
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              x_out,
    output logic              x_valid,
    output logic              busy,
    output logic [WCNT_W-1:0] word_count
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [WCNT_W-1:0] word_count_q, word_count_d;
    logic              x_out_q, x_out_d, x_valid_q, x_valid_d;
    logic              busy_q, busy_d, ready_q, ready_d;
    logic              load, shift, nxt_bit, done;
`ifdef SERIALIZER_PARITY_EN
    logic              parity;
`endif
    serializer_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr (
        .clock    (clock),
        .reset    (reset),
        .load_i   (load),
        .shift_i  (shift),
        .data_i   (load_data),
`ifdef SERIALIZER_PARITY_EN
        .parity_o (parity),
`endif
        .bit_o    (nxt_bit)
    );
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gap_d        = gap_q;
        word_count_d = word_count_q;
        x_out_d      = IDLE_BIT;
        x_valid_d    = 1'b0;
        busy_d       = 1'b1;
        ready_d      = 1'b0;
        load         = 1'b0;
        shift        = 1'b0;
        done         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ready_q && load_valid) begin
                    state_d   = S_SHIFT;
                    load      = 1'b1;
                    x_out_d   = nxt_bit;
                    x_valid_d = 1'b1;
                    cnt_d     = CW'(1);
                end else begin
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt_q == CW'(WIDTH)) begin
`ifdef SERIALIZER_PARITY_EN
                    state_d   = S_PARITY;
                    x_out_d   = parity;
                    x_valid_d = 1'b1;
`else
                    done = 1'b1;
`endif
                end else begin
                    shift     = 1'b1;
                    x_out_d   = nxt_bit;
                    x_valid_d = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                end
            end
`ifdef SERIALIZER_PARITY_EN
            S_PARITY: done = 1'b1;
`endif
            S_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Word finished: count it and either idle out the gap or become ready immediately.
        if (done) begin
            word_count_d = word_count_q + WCNT_W'(1);
            state_d      = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            busy_d       = (GAP_CYCLES != 0);
            ready_d      = (GAP_CYCLES == 0);
            gap_d        = '0;
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            gap_q        <= '0;
            word_count_q <= '0;
            x_out_q      <= IDLE_BIT;
            x_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            word_count_q <= word_count_d;
            x_out_q      <= x_out_d;
            x_valid_q    <= x_valid_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
        end
    end
    assign load_ready = ready_q;
    assign x_out      = x_out_q;
    assign x_valid    = x_valid_q;
    assign busy       = busy_q;
    assign word_count = word_count_q;
endmodule

// File: tb/tb_zero_detector_bit_serializer.sv
// tb_zero_detector_bit_serializer: scoreboard bench for MSB-first/gap-2 and LSB-first/gap-0 builds
module tb_zero_detector_bit_serializer;
`ifdef SERIALIZER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  load_data = '0;
    logic        load_valid = 1'b0;
    logic        load_ready, x_out, x_valid, busy;
    logic [15:0] word_count;
    logic [7:0]  ld2_data = '0;
    logic        ld2_valid = 1'b0;
    logic        ready2, x_out2, x_valid2, busy2;
    logic [15:0] wc2;
    logic        exp_q[$];
    logic        exp2_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          exp_wc = 0;

    zero_detector_bit_serializer #(.WIDTH(8), .GAP_CYCLES(2), .MSB_FIRST(1), .IDLE_BIT(1'b1)) dut (
        .clock(clock), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready), .x_out(x_out), .x_valid(x_valid), .busy(busy),
        .word_count(word_count)
    );
    zero_detector_bit_serializer #(.WIDTH(8), .GAP_CYCLES(0), .MSB_FIRST(0), .IDLE_BIT(1'b1)) dut2 (
        .clock(clock), .reset(reset), .load_data(ld2_data), .load_valid(ld2_valid),
        .load_ready(ready2), .x_out(x_out2), .x_valid(x_valid2), .busy(busy2),
        .word_count(wc2)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (x_valid) begin
                if (exp_q.size() == 0) chk("dut_bit_unexpected", 32'(x_out), 32'hBAD);
                else chk("dut_serial_bit", 32'(x_out), 32'(exp_q.pop_front()));
            end else chk("dut_idle_level", 32'(x_out), 32'd1);
            if (x_valid2) begin
                if (exp2_q.size() == 0) chk("dut2_bit_unexpected", 32'(x_out2), 32'hBAD);
                else chk("dut2_serial_bit", 32'(x_out2), 32'(exp2_q.pop_front()));
            end else chk("dut2_idle_level", 32'(x_out2), 32'd1);
        end
    end

    task automatic send(input logic [7:0] w, input bit keep);
        int t = 0;
        @(negedge clock);
        while (!load_ready && t < 100) begin
            @(negedge clock);
            t++;
        end
        chk("ready_wait", 32'(load_ready), 32'd1);
        load_data  = w;
        load_valid = 1'b1;
        for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
        if (PB != 0) exp_q.push_back(^w);
        @(posedge clock);
        #1;
        chk("accept_vbr", 32'({x_valid, busy, load_ready}), 32'b110);
        if (!keep) load_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // reset values
        @(posedge clock);
        #1;
        chk("rst_outputs", 32'({x_out, x_valid, busy, load_ready}), 32'b1000);
        chk("rst_word_count", 32'(word_count), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("ready_after_release", 32'(load_ready), 32'd1);
        // 1: 8'hA5 MSB first with two gap cycles
        send(8'hA5, 1'b0);
        exp_wc++;
        repeat (8 + PB) @(posedge clock);
        #1;
        chk("t1_done_vbr", 32'({x_valid, busy, load_ready}), 32'b010);
        chk("t1_word_count", 32'(word_count), 32'(exp_wc));
        @(posedge clock);
        #1;
        chk("t1_gap_not_ready", 32'(load_ready), 32'd0);
        @(posedge clock);
        #1;
        chk("t1_ready_busy", 32'({busy, load_ready}), 32'b01);
        // 2: LSB first, no gap, 8'h01
        @(negedge clock);
        ld2_data  = 8'h01;
        ld2_valid = 1'b1;
        for (int i = 0; i < 8; i++) exp2_q.push_back(ld2_data[i]);
        if (PB != 0) exp2_q.push_back(1'b1);
        @(posedge clock);
        #1;
        chk("t2_accept_vbr", 32'({x_valid2, busy2, ready2}), 32'b110);
        ld2_valid = 1'b0;
        repeat (8 + PB) @(posedge clock);
        #1;
        chk("t2_done_vbr", 32'({x_valid2, busy2, ready2}), 32'b001);
        chk("t2_word_count", 32'(wc2), 32'd1);
        // 3: load_valid held across 8'hFF then 8'h00
        send(8'hFF, 1'b1);
        load_data = 8'h00;
        for (int i = 0; i < 8; i++) exp_q.push_back(1'b0);
        if (PB != 0) exp_q.push_back(1'b0);
        repeat (9 + PB) @(posedge clock);
        #1;
        chk("t3_held_not_ready", 32'({x_valid, load_ready}), 32'b00);
        @(posedge clock);
        #1;
        chk("t3_ready_no_accept", 32'({x_valid, load_ready}), 32'b01);
        @(posedge clock);
        #1;
        chk("t3_second_accept", 32'({x_valid, busy, load_ready}), 32'b110);
        load_valid = 1'b0;
        exp_wc += 2;
        repeat (10 + PB) @(posedge clock);
        #1;
        chk("t3_ready", 32'(load_ready), 32'd1);
        chk("t3_word_count", 32'(word_count), 32'(exp_wc));
        // 4: reset during bit 4 of 8'h3C
        send(8'h3C, 1'b0);
        repeat (4) @(posedge clock);
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("t4_async_outputs", 32'({x_out, x_valid, busy, load_ready}), 32'b1000);
        chk("t4_async_word_count", 32'(word_count), 32'd0);
        exp_q.delete();
        exp_wc = 0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("t4_ready_after_release", 32'({x_valid, load_ready}), 32'b01);
        // 5: word_count wrap from 16'hFFFF
        @(negedge clock);
        force dut.word_count_q = 16'hFFFF;
        @(negedge clock);
        release dut.word_count_q;
        #1;
        chk("t5_preload", 32'(word_count), 32'hFFFF);
        send(8'h81, 1'b0);
        repeat (8 + PB) @(posedge clock);
        #1;
        chk("t5_wrap", 32'(word_count), 32'd0);
        repeat (5) @(posedge clock);
        #1;
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        chk("queue2_drain", 32'(exp2_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
